spi_log_serializer: RTL and testbench
=====================================

Name: spi_log_serializer

Overview:
- Downstream consumer of the SPI flash logging interface (log_strobe/log_addr/log_len).
- Buffers read-transaction events in an event FIFO and serializes each one into bytes for the UART/USB-serial transmit port, honouring tx backpressure.
- Arbitrates the same transmit port with the user command parser's byte stream.
- Drops events cleanly on overflow and counts the drops.

Parameters:
- DEPTH, 16, event FIFO entries; power of two, 2..256.
- HEX_MODE, 0, 0 = 4-byte binary frame, 1 = 10-byte ASCII frame.

Ports:
- clk  input  1  system clock (132 MHz domain)
- reset  input  1  asynchronous, active-high
- log_strobe  input  1  one-cycle pulse; log_addr/log_len valid
- log_addr  input  24  flash byte address of transaction
- log_len  input  8  transaction length in bytes (saturated by producer)
- pause  input  1  high = do not start new frames (spi_critical)
- user_txd  input  8  user parser byte
- user_txd_strobe  input  1  user byte valid, only when user_txd_ready
- user_txd_ready  output  1  user byte will be accepted this cycle
- uart_txd  output  8  byte to serial port
- uart_txd_strobe  output  1  one-cycle byte-send pulse
- uart_txd_ready  input  1  serial port can take a byte
- fifo_count  output  log2(DEPTH)+1  events buffered
- dropped  output  8  events lost to overflow, saturating at 255
- overflow  output  1  sticky; set on any drop

Behaviour:
- Reset (async): FIFO empty, fifo_count = 0, dropped = 0, overflow = 0, uart_txd_strobe = 0, uart_txd = 0, user_txd_ready = 0, FSM = IDLE.
- Event FIFO:
  - Entry = {log_addr, log_len}, 32 bits.
  - Write on log_strobe when not full.
  - log_strobe when full: entry discarded, dropped increments (saturating), overflow set.
  - Simultaneous write and pop when full: the pop frees space first, so the write is accepted and no drop occurs.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE:
  - FIFO non-empty and !pause -> LOAD. Event priority: user bytes are not accepted this cycle.
  - Otherwise user_txd_ready = uart_txd_ready && !pause. An accepted user byte drives uart_txd = user_txd and uart_txd_strobe = 1 on the next cycle, then -> GAP.
- LOAD:
  - Pop the FIFO head into a frame shift register.
  - byte_idx = 0; nbytes = 4 (binary) or 10 (hex).
  - -> SEND.
- SEND:
  - When uart_txd_ready: emit the frame byte at byte_idx (strobe registered, 1 cycle), increment byte_idx, -> GAP.
  - If uart_txd_ready is low, hold with no strobe.
- GAP:
  - Exactly one cycle, because ready may lag a strobe by one cycle.
  - -> SEND if byte_idx < nbytes, else -> IDLE.
  - Consequence: at most one strobe every 2 cycles.
- pause affects only frame start. A frame in progress always completes. Reset mid-frame abandons it with no partial-frame recovery.
- Binary frame, MSB first: addr[23:16], addr[15:8], addr[7:0], len.
- Hex frame:
  - Six uppercase ASCII hex digits of addr (MSB nibble first), then two digits of len, then 0x0D, 0x0A.
  - Digits 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
- Latency: log_strobe into an empty FIFO in IDLE with ready high gives the first uart_txd_strobe 3 cycles later (FIFO write, LOAD, SEND register).
- user_txd_ready is 0 in every state except IDLE.

Decomposition:
- Shared package `spispy_pkg`:
  - FSM state enum.
  - Frame length constants (4, 10).
  - ASCII constants CR = 0x0D, LF = 0x0A.
  - A nibble-to-ASCII hex function, also usable by the user parser.
- One natural sub-module: `sync_fifo` (parameterised width/depth, count, full/empty, same-cycle read+write).
- FSM and formatter stay in this module.

Test Plan:
- HEX_MODE=0, ready held high, one event addr=0x123456 len=0x20 -> bytes 0x12, 0x34, 0x56, 0x20; strobes on cycles 3, 5, 7, 9 after log_strobe; FSM returns to IDLE.
- HEX_MODE=1, addr=0x00ABCD len=0x0F -> bytes "00ABCD0F" then 0x0D 0x0A, 10 strobes total.
- DEPTH=16, pause high, 20 log_strobes -> fifo_count = 16, dropped = 4, overflow = 1, no strobes. Release pause -> 16 frames in FIFO order.
- Toggle uart_txd_ready low for 5 cycles mid-frame -> no strobe while low, no byte lost or duplicated, and no strobe in the cycle immediately after any strobe.
- User byte 0x41 offered while a frame is in SEND -> user_txd_ready = 0 until IDLE. After the frame ends, 0x41 is emitted. If an event and a user byte arrive simultaneously in IDLE, the event frame goes first.
- Assert reset mid-frame after 2 of 4 bytes -> all outputs go to reset values immediately; FIFO empty; next event produces a full fresh frame.

Source files
------------

// File: rtl/spispy_pkg.sv
// Shared definitions for the SPI-spy logging path: serializer FSM states, frame
// sizes, ASCII framing bytes and a nibble-to-hex helper the user parser also uses.
package spispy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } serState_t;

    localparam int BIN_FRAME_LEN = 4;
    localparam int HEX_FRAME_LEN = 10;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase ASCII: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
    function automatic logic [7:0] nibbleToHex(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and show-ahead read data; a read and a
// write in the same cycle are both honoured, even when the FIFO is full.
module sync_fifo import spispy_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wrEn,
    input  logic [WIDTH-1:0]       i_wrData,
    input  logic                   i_rdEn,
    output logic [WIDTH-1:0]       o_rdData,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doWrite;
    logic             w_doRead;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_doRead  = i_rdEn && !o_empty;
    // The slot freed by a same-cycle read lets a full FIFO accept the write.
    assign w_doWrite = i_wrEn && (!o_full || w_doRead);
    assign o_rdData  = r_mem[r_rdPtr];
    assign o_count   = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_doWrite && !w_doRead) begin
                r_count <= r_count + 1'b1;
            end else if (w_doRead && !w_doWrite) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

endmodule

// File: rtl/spi_log_serializer.sv
// Serializes buffered SPI flash read events into binary or ASCII-hex frames on the
// shared serial transmit port, slotting user parser bytes in between frames.
module spi_log_serializer import spispy_pkg::*; #(
    parameter int DEPTH    = 16,
    parameter int HEX_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   log_strobe,
    input  logic [23:0]            log_addr,
    input  logic [7:0]             log_len,
    input  logic                   pause,
    input  logic [7:0]             user_txd,
    input  logic                   user_txd_strobe,
    output logic                   user_txd_ready,
    output logic [7:0]             uart_txd,
    output logic                   uart_txd_strobe,
    input  logic                   uart_txd_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             dropped,
    output logic                   overflow
);

    localparam logic [3:0] NBYTES = (HEX_MODE != 0) ? 4'(HEX_FRAME_LEN) : 4'(BIN_FRAME_LEN);

    serState_t   r_state;
    serState_t   w_nextState;
    logic [31:0] r_frame;
    logic [3:0]  r_byteIdx;
    logic [7:0]  r_uartTxd;
    logic        r_uartStrobe;
    logic [7:0]  r_dropped;
    logic        r_overflow;

    logic [31:0] w_fifoHead;
    logic        w_fifoFull;
    logic        w_fifoEmpty;
    logic        w_pop;
    logic        w_drop;
    logic        w_emit;
    logic        w_userAccept;
    logic        w_userReady;
    logic [3:0]  w_nibble;
    logic [7:0]  w_frameByte;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_eventFifo (
        .clk      (clk),
        .reset    (reset),
        .i_wrEn   (log_strobe),
        .i_wrData ({log_addr, log_len}),
        .i_rdEn   (w_pop),
        .o_rdData (w_fifoHead),
        .o_count  (fifo_count),
        .o_full   (w_fifoFull),
        .o_empty  (w_fifoEmpty)
    );

    assign w_drop = log_strobe && w_fifoFull && !w_pop;

    always_comb begin
        w_nextState  = r_state;
        w_pop        = 1'b0;
        w_emit       = 1'b0;
        w_userAccept = 1'b0;
        w_userReady  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifoEmpty && !pause) begin
                    w_nextState = ST_LOAD;
                end else begin
                    // A log event arriving this cycle outranks a user byte offered alongside it.
                    w_userReady = uart_txd_ready && !pause && !log_strobe && !reset;
                    if (user_txd_strobe && w_userReady) begin
                        w_userAccept = 1'b1;
                        w_nextState  = ST_GAP;
                    end
                end
            end
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_nextState = ST_SEND;
            end
            ST_SEND: begin
                if (uart_txd_ready) begin
                    w_emit      = 1'b1;
                    w_nextState = ST_GAP;
                end
            end
            ST_GAP: begin
                w_nextState = (r_byteIdx < NBYTES) ? ST_SEND : ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_nibble    = r_frame[5'd31 - {r_byteIdx[2:0], 2'b00} -: 4];
        w_frameByte = 8'h00;
        if (HEX_MODE != 0) begin
            if (r_byteIdx == 4'd8) begin
                w_frameByte = ASCII_CR;
            end else if (r_byteIdx == 4'd9) begin
                w_frameByte = ASCII_LF;
            end else begin
                w_frameByte = nibbleToHex(w_nibble);
            end
        end else begin
            w_frameByte = r_frame[5'd31 - {r_byteIdx[1:0], 3'b000} -: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_frame      <= '0;
            r_byteIdx    <= '0;
            r_uartTxd    <= '0;
            r_uartStrobe <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_uartStrobe <= w_emit || w_userAccept;
            if (w_pop) begin
                r_frame   <= w_fifoHead;
                r_byteIdx <= '0;
            end
            if (w_emit) begin
                r_uartTxd <= w_frameByte;
                r_byteIdx <= r_byteIdx + 4'd1;
            end
            // Parking the index at the frame end sends the following gap straight back to idle.
            if (w_userAccept) begin
                r_uartTxd <= user_txd;
                r_byteIdx <= NBYTES;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dropped  <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropped != 8'hFF) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end
    end

    assign user_txd_ready  = w_userReady;
    assign uart_txd        = r_uartTxd;
    assign uart_txd_strobe = r_uartStrobe;
    assign dropped         = r_dropped;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_spi_log_serializer.sv
// Drives a binary-frame and a hex-frame serializer with identical traffic and checks
// their byte streams against a frame-level reference model.
module tb_spi_log_serializer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        logStrobe;
    logic [23:0] logAddr;
    logic [7:0]  logLen;
    logic        pause;
    logic [7:0]  userTxd;
    logic        uartReady;
    logic        userStrobeB, userStrobeH;
    logic        userReadyB, userReadyH;
    logic [7:0]  txdB, txdH;
    logic        strobeB, strobeH;
    logic [4:0]  countB, countH;
    logic [7:0]  droppedB, droppedH;
    logic        overflowB, overflowH;

    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    logic        pendB = 1'b0, pendH = 1'b0;
    logic [7:0]  expB[$], expH[$], gotB[$], gotH[$];
    int          cycB[$], cycH[$];
    int          spacingViolB = 0, spacingViolH = 0, readyViolB = 0, readyViolH = 0;
    logic        prevStrobeB = 1'b0, prevStrobeH = 1'b0, readyPrev = 1'b0;
    string       hexChars = "0123456789ABCDEF";

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    spi_log_serializer #(.DEPTH(DEPTH), .HEX_MODE(0)) dutBin (
        .clk(clk), .reset(reset), .log_strobe(logStrobe), .log_addr(logAddr), .log_len(logLen),
        .pause(pause), .user_txd(userTxd), .user_txd_strobe(userStrobeB), .user_txd_ready(userReadyB),
        .uart_txd(txdB), .uart_txd_strobe(strobeB), .uart_txd_ready(uartReady),
        .fifo_count(countB), .dropped(droppedB), .overflow(overflowB)
    );

    spi_log_serializer #(.DEPTH(DEPTH), .HEX_MODE(1)) dutHex (
        .clk(clk), .reset(reset), .log_strobe(logStrobe), .log_addr(logAddr), .log_len(logLen),
        .pause(pause), .user_txd(userTxd), .user_txd_strobe(userStrobeH), .user_txd_ready(userReadyH),
        .uart_txd(txdH), .uart_txd_strobe(strobeH), .uart_txd_ready(uartReady),
        .fifo_count(countH), .dropped(droppedH), .overflow(overflowH)
    );

    // Byte capture plus the pacing rules: no back-to-back strobes, and a strobe only
    // after an edge at which the serial port reported ready.
    always @(negedge clk) begin
        if (!reset) begin
            if (strobeB) begin
                gotB.push_back(txdB);
                cycB.push_back(cycleCnt);
                if (prevStrobeB) spacingViolB++;
                if (!readyPrev) readyViolB++;
            end
            if (strobeH) begin
                gotH.push_back(txdH);
                cycH.push_back(cycleCnt);
                if (prevStrobeH) spacingViolH++;
                if (!readyPrev) readyViolH++;
            end
        end
        prevStrobeB = strobeB;
        prevStrobeH = strobeH;
        readyPrev   = uartReady;
    end

    function automatic void expectEvent(input logic [23:0] a, input logic [7:0] l);
        expB.push_back(8'(a / 65536));
        expB.push_back(8'(a / 256));
        expB.push_back(8'(a));
        expB.push_back(l);
        for (int i = 5; i >= 0; i--) expH.push_back(hexChars.getc(int'(a >> (4 * i)) % 16));
        expH.push_back(hexChars.getc(int'(l) / 16));
        expH.push_back(hexChars.getc(int'(l) % 16));
        expH.push_back(8'd13);
        expH.push_back(8'd10);
    endfunction

    task automatic clearScoreboard();
        expB.delete(); expH.delete(); gotB.delete(); gotH.delete();
        cycB.delete(); cycH.delete();
        pendB = 1'b0; pendH = 1'b0;
    endtask

    // One clock: offer pending user bytes only while ready, then return #1 after the edge.
    task automatic step();
        #1;
        userStrobeB = pendB && userReadyB;
        userStrobeH = pendH && userReadyH;
        @(posedge clk);
        if (userStrobeB) pendB = 1'b0;
        if (userStrobeH) pendH = 1'b0;
        #1;
        logStrobe = 1'b0; userStrobeB = 1'b0; userStrobeH = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && (gotB.size() < expB.size() || gotH.size() < expH.size()); i++) step();
        repeat (4) step();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({strobeB, txdB, countB, droppedB, overflowB} !== '0) begin
            errors++; $display("[TB] FAIL reset_bin_outputs: got %b expected 0", {strobeB, txdB, countB, droppedB, overflowB});
        end
        checks++;
        if ({strobeH, txdH, countH, droppedH, overflowH} !== '0) begin
            errors++; $display("[TB] FAIL reset_hex_outputs: got %b expected 0", {strobeH, txdH, countH, droppedH, overflowH});
        end
        checks++;
        if ({userReadyB, userReadyH} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_user_ready: got %b expected 00", {userReadyB, userReadyH});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({userReadyB, userReadyH} !== 2'b11) begin
            errors++; $display("[TB] FAIL idle_user_ready: got %b expected 11", {userReadyB, userReadyH});
        end
        step();
        step();
    endtask

    task automatic test_binary_frame();
        int c0;
        clearScoreboard();
        logAddr = 24'h123456; logLen = 8'h20; logStrobe = 1'b1;
        expectEvent(24'h123456, 8'h20);
        step();
        c0 = cycleCnt;
        drain(200);
        checks++;
        if (gotB.size() !== expB.size()) begin errors++; $display("[TB] FAIL bin1_len: got %0d expected %0d", gotB.size(), expB.size()); end
        checks++;
        if (gotH.size() !== expH.size()) begin errors++; $display("[TB] FAIL hex1_len: got %0d expected %0d", gotH.size(), expH.size()); end
        for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
            checks++;
            if (gotB[i] !== expB[i]) begin errors++; $display("[TB] FAIL bin1_byte[%0d]: got %h expected %h", i, gotB[i], expB[i]); end
        end
        for (int i = 0; i < expH.size() && i < gotH.size(); i++) begin
            checks++;
            if (gotH[i] !== expH[i]) begin errors++; $display("[TB] FAIL hex1_byte[%0d]: got %h expected %h", i, gotH[i], expH[i]); end
        end
        for (int i = 0; i < cycB.size(); i++) begin
            checks++;
            if (cycB[i] - c0 !== 3 + 2 * i) begin errors++; $display("[TB] FAIL bin1_timing[%0d]: got %0d expected %0d", i, cycB[i] - c0, 3 + 2 * i); end
        end
        for (int i = 0; i < cycH.size(); i++) begin
            checks++;
            if (cycH[i] - c0 !== 3 + 2 * i) begin errors++; $display("[TB] FAIL hex1_timing[%0d]: got %0d expected %0d", i, cycH[i] - c0, 3 + 2 * i); end
        end
        #1;
        checks++;
        if ({userReadyB, userReadyH} !== 2'b11) begin errors++; $display("[TB] FAIL bin1_back_idle: got %b expected 11", {userReadyB, userReadyH}); end
    endtask

    task automatic test_hex_frame();
        clearScoreboard();
        logAddr = 24'h00ABCD; logLen = 8'h0F; logStrobe = 1'b1;
        expectEvent(24'h00ABCD, 8'h0F);
        step();
        drain(200);
        checks++;
        if (gotH.size() !== 10) begin errors++; $display("[TB] FAIL hex2_len: got %0d expected 10", gotH.size()); end
        checks++;
        if (gotB.size() !== 4) begin errors++; $display("[TB] FAIL bin2_len: got %0d expected 4", gotB.size()); end
        for (int i = 0; i < expH.size() && i < gotH.size(); i++) begin
            checks++;
            if (gotH[i] !== expH[i]) begin errors++; $display("[TB] FAIL hex2_byte[%0d]: got %h expected %h", i, gotH[i], expH[i]); end
        end
        for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
            checks++;
            if (gotB[i] !== expB[i]) begin errors++; $display("[TB] FAIL bin2_byte[%0d]: got %h expected %h", i, gotB[i], expB[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [23:0] a;
        logic [7:0]  l;
        clearScoreboard();
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 24'($urandom); l = 8'($urandom);
            logAddr = a; logLen = l; logStrobe = 1'b1;
            if (i < DEPTH) expectEvent(a, l);
            step();
        end
        repeat (3) step();
        checks++;
        if ({countB, countH} !== {5'd16, 5'd16}) begin errors++; $display("[TB] FAIL ovf_count: got %0d/%0d expected 16", countB, countH); end
        checks++;
        if ({droppedB, droppedH} !== {8'd4, 8'd4}) begin errors++; $display("[TB] FAIL ovf_dropped: got %0d/%0d expected 4", droppedB, droppedH); end
        checks++;
        if ({overflowB, overflowH} !== 2'b11) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 11", {overflowB, overflowH}); end
        checks++;
        if (gotB.size() + gotH.size() !== 0) begin errors++; $display("[TB] FAIL ovf_paused_strobes: got %0d expected 0", gotB.size() + gotH.size()); end
        pause = 1'b0;
        drain(2000);
        checks++;
        if (gotB.size() !== expB.size()) begin errors++; $display("[TB] FAIL ovf_bin_len: got %0d expected %0d", gotB.size(), expB.size()); end
        checks++;
        if (gotH.size() !== expH.size()) begin errors++; $display("[TB] FAIL ovf_hex_len: got %0d expected %0d", gotH.size(), expH.size()); end
        for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
            checks++;
            if (gotB[i] !== expB[i]) begin errors++; $display("[TB] FAIL ovf_bin_byte[%0d]: got %h expected %h", i, gotB[i], expB[i]); end
        end
        for (int i = 0; i < expH.size() && i < gotH.size(); i++) begin
            checks++;
            if (gotH[i] !== expH[i]) begin errors++; $display("[TB] FAIL ovf_hex_byte[%0d]: got %h expected %h", i, gotH[i], expH[i]); end
        end
        checks++;
        if ({countB, countH} !== 10'd0) begin errors++; $display("[TB] FAIL ovf_drained: got %0d/%0d expected 0", countB, countH); end
    endtask

    task automatic test_backpressure();
        logic [23:0] a;
        logic [7:0]  l;
        int          nB, nH;
        clearScoreboard();
        a = 24'($urandom); l = 8'($urandom);
        logAddr = a; logLen = l; logStrobe = 1'b1;
        expectEvent(a, l);
        step();
        for (int i = 0; i < 100 && gotB.size() < 2; i++) step();
        uartReady = 1'b0;
        step();
        nB = gotB.size(); nH = gotH.size();
        repeat (4) step();
        checks++;
        if (gotB.size() !== nB || gotH.size() !== nH) begin
            errors++; $display("[TB] FAIL bp_hold: got %0d/%0d bytes expected %0d/%0d", gotB.size(), gotH.size(), nB, nH);
        end
        uartReady = 1'b1;
        drain(500);
        for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
            checks++;
            if (gotB[i] !== expB[i]) begin errors++; $display("[TB] FAIL bp_bin_byte[%0d]: got %h expected %h", i, gotB[i], expB[i]); end
        end
        for (int i = 0; i < expH.size() && i < gotH.size(); i++) begin
            checks++;
            if (gotH[i] !== expH[i]) begin errors++; $display("[TB] FAIL bp_hex_byte[%0d]: got %h expected %h", i, gotH[i], expH[i]); end
        end
        checks++;
        if (gotB.size() !== expB.size() || gotH.size() !== expH.size()) begin
            errors++; $display("[TB] FAIL bp_len: got %0d/%0d expected %0d/%0d", gotB.size(), gotH.size(), expB.size(), expH.size());
        end
        checks++;
        if (spacingViolB + spacingViolH + readyViolB + readyViolH !== 0) begin
            errors++; $display("[TB] FAIL bp_pacing: got %0d violations expected 0", spacingViolB + spacingViolH + readyViolB + readyViolH);
        end
        checks++;
        if ({droppedB, overflowB} !== {8'd4, 1'b1}) begin errors++; $display("[TB] FAIL bp_drop_held: got %0d/%b expected 4/1", droppedB, overflowB); end
    endtask

    task automatic test_user_priority();
        logic [23:0] a;
        logic [7:0]  l;
        clearScoreboard();
        a = 24'($urandom); l = 8'($urandom);
        logAddr = a; logLen = l; logStrobe = 1'b1;
        expectEvent(a, l);
        step();
        for (int i = 0; i < 100 && gotB.size() < 1; i++) step();
        userTxd = 8'h41; pendB = 1'b1; pendH = 1'b1;
        for (int i = 0; i < 200 && gotH.size() < 10; i++) begin
            #1;
            if (gotB.size() < 4) begin
                checks++;
                if (userReadyB !== 1'b0) begin errors++; $display("[TB] FAIL usr_bin_blocked: got %b expected 0", userReadyB); end
            end
            checks++;
            if (userReadyH !== 1'b0) begin errors++; $display("[TB] FAIL usr_hex_blocked: got %b expected 0", userReadyH); end
            step();
        end
        expB.push_back(8'h41); expH.push_back(8'h41);
        drain(300);
        // Event and user byte offered together: the frame must precede the user byte.
        a = 24'($urandom); l = 8'($urandom);
        logAddr = a; logLen = l; logStrobe = 1'b1;
        userTxd = 8'h5A; pendB = 1'b1; pendH = 1'b1;
        expectEvent(a, l);
        expB.push_back(8'h5A); expH.push_back(8'h5A);
        step();
        drain(300);
        checks++;
        if (gotB.size() !== expB.size() || gotH.size() !== expH.size()) begin
            errors++; $display("[TB] FAIL usr_len: got %0d/%0d expected %0d/%0d", gotB.size(), gotH.size(), expB.size(), expH.size());
        end
        for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
            checks++;
            if (gotB[i] !== expB[i]) begin errors++; $display("[TB] FAIL usr_bin_byte[%0d]: got %h expected %h", i, gotB[i], expB[i]); end
        end
        for (int i = 0; i < expH.size() && i < gotH.size(); i++) begin
            checks++;
            if (gotH[i] !== expH[i]) begin errors++; $display("[TB] FAIL usr_hex_byte[%0d]: got %h expected %h", i, gotH[i], expH[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] a;
        logic [7:0]  l;
        clearScoreboard();
        for (int i = 0; i < 3; i++) begin
            logAddr = 24'($urandom); logLen = 8'($urandom); logStrobe = 1'b1;
            step();
        end
        for (int i = 0; i < 100 && gotB.size() < 2; i++) step();
        reset = 1'b1;
        #1;
        checks++;
        if ({strobeB, txdB, strobeH, txdH} !== 18'd0) begin
            errors++; $display("[TB] FAIL rst_tx: got %b expected 0", {strobeB, txdB, strobeH, txdH});
        end
        checks++;
        if ({countB, countH} !== 10'd0) begin errors++; $display("[TB] FAIL rst_fifo: got %0d/%0d expected 0", countB, countH); end
        checks++;
        if ({droppedB, overflowB, droppedH, overflowH} !== 18'd0) begin
            errors++; $display("[TB] FAIL rst_drop: got %0d/%b/%0d/%b expected 0", droppedB, overflowB, droppedH, overflowH);
        end
        checks++;
        if ({userReadyB, userReadyH} !== 2'b00) begin errors++; $display("[TB] FAIL rst_user_ready: got %b expected 00", {userReadyB, userReadyH}); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clearScoreboard();
        a = 24'($urandom); l = 8'($urandom);
        logAddr = a; logLen = l; logStrobe = 1'b1;
        expectEvent(a, l);
        step();
        drain(300);
        checks++;
        if (gotB.size() !== expB.size() || gotH.size() !== expH.size()) begin
            errors++; $display("[TB] FAIL rst_fresh_len: got %0d/%0d expected %0d/%0d", gotB.size(), gotH.size(), expB.size(), expH.size());
        end
        for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
            checks++;
            if (gotB[i] !== expB[i]) begin errors++; $display("[TB] FAIL rst_bin_byte[%0d]: got %h expected %h", i, gotB[i], expB[i]); end
        end
        for (int i = 0; i < expH.size() && i < gotH.size(); i++) begin
            checks++;
            if (gotH[i] !== expH[i]) begin errors++; $display("[TB] FAIL rst_hex_byte[%0d]: got %h expected %h", i, gotH[i], expH[i]); end
        end
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [7:0]  l;
        int          nEvents;
        clearScoreboard();
        for (int r = 0; r < 6; r++) begin
            nEvents = $urandom_range(1, 8);
            for (int e = 0; e < nEvents; e++) begin
                repeat ($urandom_range(0, 3)) begin
                    uartReady = ($urandom_range(0, 9) < 7);
                    pause = ($urandom_range(0, 9) < 2);
                    step();
                end
                a = 24'($urandom); l = 8'($urandom);
                logAddr = a; logLen = l; logStrobe = 1'b1;
                uartReady = ($urandom_range(0, 9) < 7);
                pause = ($urandom_range(0, 9) < 2);
                expectEvent(a, l);
                step();
            end
            for (int i = 0; i < 400; i++) begin
                uartReady = ($urandom_range(0, 9) < 7);
                pause = 1'b0;
                if (gotB.size() >= expB.size() && gotH.size() >= expH.size()) break;
                step();
            end
            uartReady = 1'b1;
            drain(1000);
        end
        checks++;
        if (gotB.size() !== expB.size() || gotH.size() !== expH.size()) begin
            errors++; $display("[TB] FAIL rnd_len: got %0d/%0d expected %0d/%0d", gotB.size(), gotH.size(), expB.size(), expH.size());
        end
        for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
            checks++;
            if (gotB[i] !== expB[i]) begin errors++; $display("[TB] FAIL rnd_bin_byte[%0d]: got %h expected %h", i, gotB[i], expB[i]); end
        end
        for (int i = 0; i < expH.size() && i < gotH.size(); i++) begin
            checks++;
            if (gotH[i] !== expH[i]) begin errors++; $display("[TB] FAIL rnd_hex_byte[%0d]: got %h expected %h", i, gotH[i], expH[i]); end
        end
        checks++;
        if (spacingViolB + spacingViolH + readyViolB + readyViolH !== 0) begin
            errors++; $display("[TB] FAIL rnd_pacing: got %0d violations expected 0", spacingViolB + spacingViolH + readyViolB + readyViolH);
        end
        checks++;
        if ({droppedB, droppedH} !== 16'd0) begin errors++; $display("[TB] FAIL rnd_no_drop: got %0d/%0d expected 0", droppedB, droppedH); end
    endtask

    initial begin
        reset = 1'b1; logStrobe = 1'b0; logAddr = '0; logLen = '0; pause = 1'b0;
        userTxd = '0; uartReady = 1'b1; userStrobeB = 1'b0; userStrobeH = 1'b0;
        test_reset();
        test_binary_frame();
        test_hex_frame();
        test_overflow();
        test_backpressure();
        test_user_priority();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
